// File: rtl/nibble_add_sched_pkg.sv
// Shared types and sizing for the nibble-serial adder controller.
package nibble_add_sched_pkg;

  localparam int NIBBLES_DEF = 4;
  localparam int W_DEF       = 4 * NIBBLES_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/nibble_add_sched_add4.sv
// Single shared 4-bit adder slice with carry-in and carry-out.
module nibble_add4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  assign {c_o, s_o} = 5'(a_i) + 5'(b_i) + 5'(c_i);

endmodule

// File: rtl/nibble_add_sched.sv
// Round-robin arbiter and sequencer that time-shares one 4-bit adder slice
// across the nibbles of a W-bit add, LSB first.
module nibble_add_sched
  import nibble_add_sched_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF,
  localparam int W = 4 * NIBBLES
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         REQ_0,
  input  logic         REQ_1,
  input  logic [W-1:0] A_0,
  input  logic [W-1:0] B_0,
  input  logic [W-1:0] A_1,
  input  logic [W-1:0] B_1,
  input  logic         CIN_0,
  input  logic         CIN_1,
  output logic         ACK_0,
  output logic         ACK_1,
  output logic [W-1:0] SUM,
  output logic         COUT,
  output logic         BUSY,
  output logic         GRANT
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  a_q, b_q, shadow_q, sum_q;
  logic          carry_q, cout_q, ack0_q, ack1_q;
  req_id_t       grant_q, prio_q;

  logic [IW+1:0] sh;
  logic [3:0]    a_nib, b_nib, s_nib;
  logic          c_nib, last;
  logic [W-1:0]  shadow_d;
  req_id_t       gnt_d;

  assign sh    = {idx_q, 2'b00};
  assign a_nib = 4'(a_q >> sh);
  assign b_nib = 4'(b_q >> sh);
  assign last  = (idx_q == IW'(NIBBLES - 1));

  nibble_add4 u_slice (
    .a_i (a_nib),
    .b_i (b_nib),
    .c_i (carry_q),
    .s_o (s_nib),
    .c_o (c_nib)
  );

  assign shadow_d = (shadow_q & ~(W'(4'hF) << sh)) | (W'(s_nib) << sh);

  // On contention the requester that was not served last wins.
  always_comb begin
    gnt_d = 1'b0;
    if (REQ_0 && REQ_1) gnt_d = ~prio_q;
    else if (REQ_1)     gnt_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      grant_q  <= 1'b0;
      prio_q   <= 1'b1;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (REQ_0 || REQ_1) begin
            grant_q <= gnt_d;
            a_q     <= gnt_d ? A_1 : A_0;
            b_q     <= gnt_d ? B_1 : B_0;
            carry_q <= gnt_d ? CIN_1 : CIN_0;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          shadow_q <= shadow_d;
          carry_q  <= c_nib;
          idx_q    <= idx_q + IW'(1);
          // Result and ACK are loaded on the edge into DONE so they are
          // visible for the whole DONE cycle.
          if (last) begin
            sum_q   <= shadow_d;
            cout_q  <= c_nib;
            ack0_q  <= ~grant_q;
            ack1_q  <= grant_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          prio_q  <= grant_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ACK_0 = ack0_q;
  assign ACK_1 = ack1_q;
  assign SUM   = sum_q;
  assign COUT  = cout_q;
  assign BUSY  = (state_q != IDLE);
  assign GRANT = grant_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Scoreboard bench for nibble_add_sched: expected results are queued at
// request time and popped when an ACK appears.
module tb_nibble_add_sched;
  import nibble_add_sched_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_0, REQ_1, CIN_0, CIN_1;
  logic [15:0] A_0, B_0, A_1, B_1;
  logic        ACK_0, ACK_1, COUT, BUSY, GRANT;
  logic [15:0] SUM;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        id;
    logic [15:0] sum;
    logic        cout;
  } exp_t;
  exp_t sb[$];

  nibble_add_sched dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_0(REQ_0), .REQ_1(REQ_1),
    .A_0(A_0), .B_0(B_0), .A_1(A_1), .B_1(B_1),
    .CIN_0(CIN_0), .CIN_1(CIN_1),
    .ACK_0(ACK_0), .ACK_1(ACK_1),
    .SUM(SUM), .COUT(COUT), .BUSY(BUSY), .GRANT(GRANT)
  );

  always #5 CLK = ~CLK;

  task automatic push_exp(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] full;
    exp_t e;
    full   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.id   = id;
    e.sum  = full[15:0];
    e.cout = full[16];
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin, input bit push);
    @(negedge CLK);
    if (id) begin A_1 = a; B_1 = b; CIN_1 = cin; REQ_1 = 1'b1; end
    else    begin A_0 = a; B_0 = b; CIN_0 = cin; REQ_0 = 1'b1; end
    if (push) push_exp(id, a, b, cin);
  endtask

  task automatic wait_ack(output int cyc, output logic g0, output logic g1);
    cyc = 0; g0 = 1'b0; g1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      cyc++;
      if (ACK_0 || ACK_1) begin
        g0 = ACK_0; g1 = ACK_1;
        break;
      end
    end
  endtask

  task automatic run_single(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin,
                            output int cyc, output logic g0, output logic g1);
    drive_req(id, a, b, cin, 1'b1);
    wait_ack(cyc, g0, g1);
    REQ_0 = 1'b0;
    REQ_1 = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    REQ_0 = 0; REQ_1 = 0; CIN_0 = 0; CIN_1 = 0;
    A_0 = '0; B_0 = '0; A_1 = '0; B_1 = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if ({ACK_0, ACK_1, COUT, BUSY, GRANT} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ack0/ack1/cout/busy/grant=%b required 00000", {ACK_0, ACK_1, COUT, BUSY, GRANT});
    end
    n_vec++;
    if (SUM !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_sum: got %h required 0000", SUM);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; logic g0, g1; exp_t e;
    run_single(1'b0, 16'h1234, 16'h4321, 1'b0, cyc, g0, g1);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 5 || g0 !== 1'b1 || g1 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_ack: cycle=%0d ack0=%b ack1=%b required cycle=5 ack0=1 ack1=0", cyc, g0, g1);
    end
    n_vec++;
    if (SUM !== e.sum || COUT !== e.cout || GRANT !== e.id || BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL basic_result: sum=%h cout=%b grant=%b busy=%b required %h %b %b 1", SUM, COUT, GRANT, BUSY, e.sum, e.cout, e.id);
    end
    @(posedge CLK); #1;
    n_vec++;
    if (ACK_0 !== 1'b0 || BUSY !== 1'b0 || SUM !== e.sum) begin
      n_err++;
      $display("FAIL basic_after: ack0=%b busy=%b sum=%h required 0 0 %h", ACK_0, BUSY, SUM, e.sum);
    end
  endtask

  task automatic test_ripple();
    int cyc; logic g0, g1; exp_t e;
    run_single(1'b1, 16'hFFFF, 16'h0001, 1'b0, cyc, g0, g1);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 5 || g1 !== 1'b1 || g0 !== 1'b0 || GRANT !== 1'b1) begin
      n_err++;
      $display("FAIL ripple_ack: cycle=%0d ack0=%b ack1=%b grant=%b required 5 0 1 1", cyc, g0, g1, GRANT);
    end
    n_vec++;
    if (SUM !== e.sum || COUT !== e.cout) begin
      n_err++;
      $display("FAIL ripple_result: sum=%h cout=%b required %h %b", SUM, COUT, e.sum, e.cout);
    end
    @(posedge CLK);
  endtask

  task automatic test_back_to_back();
    int cyc; logic g0, g1; exp_t e;
    @(negedge CLK);
    A_0 = 16'h0101; B_0 = 16'h1010; CIN_0 = 1'b1;
    A_1 = 16'h8000; B_1 = 16'h8000; CIN_1 = 1'b0;
    REQ_0 = 1'b1; REQ_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(1'b0, A_0, B_0, CIN_0);
      else            push_exp(1'b1, A_1, B_1, CIN_1);
    end
    for (int k = 0; k < 4; k++) begin
      wait_ack(cyc, g0, g1);
      e = sb.pop_front();
      n_vec++;
      if (cyc !== ((k == 0) ? 5 : 6) || g0 !== ~e.id || g1 !== e.id) begin
        n_err++;
        $display("FAIL b2b_order[%0d]: cycle=%0d ack0=%b ack1=%b required cycle=%0d id=%b", k, cyc, g0, g1, (k == 0) ? 5 : 6, e.id);
      end
      n_vec++;
      if (SUM !== e.sum || COUT !== e.cout || GRANT !== e.id) begin
        n_err++;
        $display("FAIL b2b_result[%0d]: sum=%h cout=%b grant=%b required %h %b %b", k, SUM, COUT, GRANT, e.sum, e.cout, e.id);
      end
    end
    REQ_0 = 1'b0; REQ_1 = 1'b0;
    @(posedge CLK);
  endtask

  task automatic test_carry_in();
    int cyc; logic g0, g1; exp_t e;
    run_single(1'b0, 16'h000F, 16'h0000, 1'b1, cyc, g0, g1);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 5 || g0 !== 1'b1 || SUM !== e.sum || COUT !== e.cout) begin
      n_err++;
      $display("FAIL cin_small: cycle=%0d ack0=%b sum=%h cout=%b required 5 1 %h %b", cyc, g0, SUM, COUT, e.sum, e.cout);
    end
    @(posedge CLK);
    run_single(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, cyc, g0, g1);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 5 || g0 !== 1'b1 || SUM !== e.sum || COUT !== e.cout) begin
      n_err++;
      $display("FAIL cin_max: cycle=%0d ack0=%b sum=%h cout=%b required 5 1 %h %b", cyc, g0, SUM, COUT, e.sum, e.cout);
    end
    @(posedge CLK);
  endtask

  task automatic test_reset_mid();
    int cyc; int acks; logic g0, g1; exp_t e;
    drive_req(1'b1, 16'h5A5A, 16'h0F0F, 1'b1, 1'b0);
    repeat (3) @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    n_vec++;
    if (BUSY !== 1'b0 || SUM !== 16'h0000 || COUT !== 1'b0 || ACK_0 !== 1'b0 || ACK_1 !== 1'b0 || GRANT !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b sum=%h cout=%b ack=%b%b grant=%b required 0 0000 0 00 0", BUSY, SUM, COUT, ACK_0, ACK_1, GRANT);
    end
    REQ_1 = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (ACK_0 || ACK_1 || BUSY) acks++;
    end
    n_vec++;
    if (acks !== 0) begin
      n_err++;
      $display("FAIL reset_no_ack: active cycles=%0d required 0", acks);
    end
    run_single(1'b1, 16'h2222, 16'h1111, 1'b1, cyc, g0, g1);
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 5 || g1 !== 1'b1 || SUM !== e.sum || COUT !== e.cout || GRANT !== e.id) begin
      n_err++;
      $display("FAIL reset_recover: cycle=%0d ack1=%b sum=%h cout=%b grant=%b required 5 1 %h %b %b", cyc, g1, SUM, COUT, GRANT, e.sum, e.cout, e.id);
    end
    @(posedge CLK);
  endtask

  task automatic test_req_drop();
    int cyc; logic got; logic [15:0] prev; exp_t e;
    drive_req(1'b0, 16'h0F0F, 16'h7171, 1'b0, 1'b1);
    prev = SUM;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      cyc++;
      if (ACK_0 || ACK_1) begin
        got = ACK_0;
        break;
      end
      n_vec++;
      if (SUM !== prev) begin
        n_err++;
        $display("FAIL drop_sum_stable[%0d]: sum=%h required %h", cyc, SUM, prev);
      end
      if (cyc == 2) begin
        REQ_0 = 1'b0;
        A_0 = 16'hDEAD; B_0 = 16'hBEEF; CIN_0 = 1'b1;
      end
    end
    e = sb.pop_front();
    n_vec++;
    if (cyc !== 5 || got !== 1'b1 || SUM !== e.sum || COUT !== e.cout) begin
      n_err++;
      $display("FAIL req_drop: cycle=%0d ack0=%b sum=%h cout=%b required 5 1 %h %b", cyc, got, SUM, COUT, e.sum, e.cout);
    end
    @(posedge CLK); #1;
    n_vec++;
    if (ACK_0 !== 1'b0 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL drop_idle: ack0=%b busy=%b required 0 0", ACK_0, BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_back_to_back();
    test_carry_in();
    test_reset_mid();
    test_req_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
